// File: rtl/wdt_rst_pkg.sv
// Shared types and constants for the watchdog reset sequencer and watchdog timer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wdt_rst_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;

    typedef enum logic [1:0] {
        ASSERT_ALL,
        REL_PERIPH,
        HOLDOFF,
        IDLE
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_WDT = 2'd1,
        CAUSE_EXT = 2'd2
    } cause_t;

endpackage

// File: rtl/reset_req_sync.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous request level.
// Latency: pulse is high in the cycle sampled by the 3rd clk edge after the input rises.
// Backpressure: none; a held level yields exactly one single-cycle pulse.
module reset_req_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic pulse
);

    // [0],[1] synchronize; [2] holds the previous synchronized value for edge detect
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], req};
        end
    end

    assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/wdt_reset_sequencer.sv
// Ordered reset sequencer: stretch, release periph then CPU, hold watchdog off, then arm it.
// Latency: accepted request drives both resets low on the next clk edge; all outputs registered.
// Backpressure: none; requests are accepted at any time and restart the sequence.
module wdt_reset_sequencer
    import wdt_rst_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 1000,
    parameter int unsigned STAGE_GAP      = 100,
    parameter int unsigned HOLDOFF_CYCLES = 100_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wdt_reset_req,
    input  logic       ext_reset_req,
    input  logic       sw_wdt_enable,
    output logic       wdt_start,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       busy,
    output logic [1:0] last_cause,
    output logic [7:0] reset_count
);

    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             periph_q, periph_d;
    logic             cpu_q, cpu_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    cause_t           cause_q, cause_d;
    logic [7:0]       count_q, count_d;

    logic ext_pulse;
    logic wdt_accept;
    logic accept;

    reset_req_sync u_ext_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (ext_reset_req),
        .pulse (ext_pulse)
    );

    // The watchdog is only armed in IDLE, so a pulse elsewhere is spurious.
    assign wdt_accept = wdt_reset_req && (state_q == IDLE);
    assign accept     = wdt_accept || ext_pulse;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        cpu_d    = cpu_q;
        start_d  = 1'b0;
        cause_d  = cause_q;
        count_d  = count_q;

        if (accept) begin
            state_d  = ASSERT_ALL;
            cnt_d    = HOLD_LD;
            periph_d = 1'b0;
            cpu_d    = 1'b0;
            cause_d  = wdt_accept ? CAUSE_WDT : CAUSE_EXT;
            count_d  = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
        end else begin
            unique case (state_q)
                ASSERT_ALL: begin
                    if (cnt_q == '0) begin
                        state_d  = REL_PERIPH;
                        cnt_d    = GAP_LD;
                        periph_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                REL_PERIPH: begin
                    if (cnt_q == '0) begin
                        state_d = HOLDOFF;
                        cnt_d   = HOLDOFF_LD;
                        cpu_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    // wdt_start stays low on the exit edge; it follows the enable from IDLE onward
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                IDLE: begin
                    start_d = sw_wdt_enable;
                end
                default: begin
                    state_d = ASSERT_ALL;
                    cnt_d   = HOLD_LD;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ASSERT_ALL;
            cnt_q    <= HOLD_LD;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b1;
            cause_q  <= CAUSE_POR;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
        end
    end

    assign wdt_start    = start_q;
    assign periph_rst_n = periph_q;
    assign cpu_rst_n    = cpu_q;
    assign busy         = busy_q;
    assign last_cause   = cause_q;
    assign reset_count  = count_q;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Directed bench for wdt_reset_sequencer with a cause/count scoreboard popped on each sequence start.
module tb_wdt_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wdt_reset_req;
    logic       ext_reset_req;
    logic       sw_wdt_enable;
    logic       wdt_start;
    logic       periph_rst_n;
    logic       cpu_rst_n;
    logic       busy;
    logic [1:0] last_cause;
    logic [7:0] reset_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    logic prev_periph;

    typedef struct {
        logic [1:0] cause;
        logic [7:0] count;
    } exp_t;
    exp_t sb[$];

    wdt_reset_sequencer #(
        .HOLD_CYCLES    (4),
        .STAGE_GAP      (2),
        .HOLDOFF_CYCLES (8),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wdt_reset_req (wdt_reset_req),
        .ext_reset_req (ext_reset_req),
        .sw_wdt_enable (sw_wdt_enable),
        .wdt_start     (wdt_start),
        .periph_rst_n  (periph_rst_n),
        .cpu_rst_n     (cpu_rst_n),
        .busy          (busy),
        .last_cause    (last_cause),
        .reset_count   (reset_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] cause);
        exp_t e;
        exp_count = (exp_count == 255) ? 255 : exp_count + 1;
        e.cause = cause;
        e.count = 8'(exp_count);
        sb.push_back(e);
    endtask

    // Advance one cycle; a request-driven fall of periph_rst_n pops the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n === 1'b1 && prev_periph === 1'b1 && periph_rst_n === 1'b0) begin
            if (sb.size() == 0) begin
                chk("sb_depth", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("sb_cause", last_cause, e.cause);
                chk("sb_count", reset_count, e.count);
            end
        end
        prev_periph = periph_rst_n;
    endtask

    // Called while the first cycle of both-resets-low is visible.
    task automatic seq_check(input bit spur);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_periph", periph_rst_n, 0);
            chk("hold_cpu", cpu_rst_n, 0);
            chk("hold_busy", busy, 1);
        end
        step();
        chk("rel_periph", periph_rst_n, 1);
        chk("rel_cpu_low", cpu_rst_n, 0);
        step();
        chk("gap_cpu_low", cpu_rst_n, 0);
        step();
        chk("rel_cpu", cpu_rst_n, 1);
        for (int i = 1; i <= 8; i++) begin
            if (spur && i == 3) wdt_reset_req = 1'b1;
            step();
            wdt_reset_req = 1'b0;
            chk("holdoff_start_low", wdt_start, 0);
            chk("holdoff_busy", busy, (i == 8) ? 0 : 1);
            chk("holdoff_periph", periph_rst_n, 1);
        end
        step();
        chk("wdt_start_rise", wdt_start, 1);
        chk("idle_busy", busy, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) step();
        chk("wait_idle", busy, 0);
    endtask

    task automatic chk_por_state();
        chk("por_periph", periph_rst_n, 0);
        chk("por_cpu", cpu_rst_n, 0);
        chk("por_start", wdt_start, 0);
        chk("por_busy", busy, 1);
        chk("por_cause", last_cause, 0);
        chk("por_count", reset_count, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        wdt_reset_req = 1'b0;
        ext_reset_req = 1'b0;
        sw_wdt_enable = 1'b1;
        prev_periph   = 1'b0;

        // Power-on
        repeat (3) step();
        chk_por_state();
        rst_n = 1'b1;
        seq_check(1'b0);
        chk("po_cause", last_cause, 0);
        chk("po_count", reset_count, 0);

        // Enable falling in IDLE drops wdt_start next edge
        sw_wdt_enable = 1'b0;
        step();
        chk("en_fall", wdt_start, 0);
        sw_wdt_enable = 1'b1;
        step();
        chk("en_rise", wdt_start, 1);

        // Watchdog pulse in IDLE, then a spurious one during HOLDOFF
        wdt_reset_req = 1'b1;
        push_exp(2'd1);
        step();
        wdt_reset_req = 1'b0;
        chk("wdt_periph_low", periph_rst_n, 0);
        chk("wdt_cpu_low", cpu_rst_n, 0);
        chk("wdt_start_low", wdt_start, 0);
        seq_check(1'b1);
        chk("spur_count", reset_count, 1);
        chk("spur_cause", last_cause, 1);

        // Button held: one sequence, starting 3 cycles after the press
        ext_reset_req = 1'b1;
        push_exp(2'd2);
        step();
        chk("btn_lat1", periph_rst_n, 1);
        step();
        chk("btn_lat2", periph_rst_n, 1);
        step();
        chk("btn_lat3", periph_rst_n, 0);
        seq_check(1'b0);
        repeat (4) step();
        chk("btn_single_busy", busy, 0);
        chk("btn_count", reset_count, 2);
        chk("btn_cause", last_cause, 2);
        ext_reset_req = 1'b0;
        repeat (4) step();

        // Button press landing in REL_PERIPH
        wdt_reset_req = 1'b1;
        push_exp(2'd1);
        step();
        wdt_reset_req = 1'b0;
        step();
        step();
        ext_reset_req = 1'b1;
        push_exp(2'd2);
        step();
        chk("rp_hold", periph_rst_n, 0);
        step();
        chk("rp_released", periph_rst_n, 1);
        step();
        chk("rp_reassert", periph_rst_n, 0);
        chk("rp_cpu", cpu_rst_n, 0);
        seq_check(1'b0);
        chk("rp_count", reset_count, 4);
        ext_reset_req = 1'b0;
        repeat (4) step();

        // Simultaneous watchdog pulse and ext_pulse in IDLE
        ext_reset_req = 1'b1;
        step();
        step();
        wdt_reset_req = 1'b1;
        push_exp(2'd1);
        step();
        wdt_reset_req = 1'b0;
        chk("sim_count", reset_count, 5);
        chk("sim_cause", last_cause, 1);
        seq_check(1'b0);
        ext_reset_req = 1'b0;
        repeat (4) step();

        // Saturation: 300 accepted requests in total
        for (int k = 0; k < 295; k++) begin
            wait_idle();
            wdt_reset_req = 1'b1;
            push_exp(2'd1);
            step();
            wdt_reset_req = 1'b0;
        end
        chk("sat_count", reset_count, 255);

        // rst_n mid-HOLDOFF forces power-on
        repeat (8) step();
        chk("pre_rst_cpu", cpu_rst_n, 1);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        step();
        chk_por_state();
        step();
        rst_n = 1'b1;
        seq_check(1'b0);
        chk("post_rst_count", reset_count, 0);
        chk("post_rst_cause", last_cause, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
